// File: rtl/fb_arbiter.sv
// Framebuffer bus arbiter: shares one Wishbone classic slave between the display
// line fetcher (m0, urgency-priority) and the drawing writer (m1, round-robin otherwise).
module fb_arbiter #(
    parameter int AW       = 24,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic            pixel_clk,
    input  logic            pixel_rst,
    input  logic            m0_cyc,
    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW-1:0]   m0_dat_w,
    input  logic [DW/8-1:0] m0_sel,
    output logic            m0_ack,
    output logic            m0_err,
    output logic [DW-1:0]   m0_dat_r,
    input  logic            m1_cyc,
    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW-1:0]   m1_dat_w,
    input  logic [DW/8-1:0] m1_sel,
    output logic            m1_ack,
    output logic            m1_err,
    output logic [DW-1:0]   m1_dat_r,
    input  logic            disp_urgent,
    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_dat_w,
    output logic [DW/8-1:0] s_sel,
    input  logic            s_ack,
    input  logic            s_err,
    input  logic [DW-1:0]   s_dat_r,
    output logic [1:0]      grant,
    output logic [7:0]      err_count
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    state_t        state, state_nxt;
    logic          last, last_nxt;        // 1: m1 was granted most recently
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [TW-1:0] to_cnt, to_nxt;
    logic [7:0]    err_nxt;
    logic          timeout;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            hold_cnt  <= '0;
            to_cnt    <= '0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            hold_cnt  <= hold_nxt;
            to_cnt    <= to_nxt;
            err_count <= err_nxt;
        end
    end

    assign grant = state;

    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        case (state)
            G0: begin
                s_cyc   = m0_cyc;
                s_stb   = m0_stb;
                s_we    = m0_we;
                s_adr   = m0_adr;
                s_dat_w = m0_dat_w;
                s_sel   = m0_sel;
            end
            G1: begin
                s_cyc   = m1_cyc;
                s_stb   = m1_stb;
                s_we    = m1_we;
                s_adr   = m1_adr;
                s_dat_w = m1_dat_w;
                s_sel   = m1_sel;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        hold_nxt  = hold_cnt;
        to_nxt    = to_cnt;
        err_nxt   = err_count;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (m0_cyc && (disp_urgent || last || !m1_cyc)) begin
                    state_nxt = G0;
                    last_nxt  = 1'b0;
                    hold_nxt  = '0;
                    to_nxt    = '0;
                end else if (m1_cyc) begin
                    state_nxt = G1;
                    last_nxt  = 1'b1;
                    hold_nxt  = '0;
                    to_nxt    = '0;
                end
            end
            G0, G1: begin
                // A slave ack or err in the expiry cycle terminates normally instead.
                timeout = s_cyc && s_stb && !s_ack && !s_err && (to_cnt == TW'(TIMEOUT));
                if (timeout) begin
                    err_nxt   = sat_inc(err_count);
                    state_nxt = IDLE;
                end else begin
                    if (s_ack || s_err)
                        to_nxt = '0;
                    else if (s_cyc && s_stb)
                        to_nxt = to_cnt + TW'(1);
                    if (state == G1) begin
                        if (!disp_urgent)
                            hold_nxt = '0;
                        else if (s_ack)
                            hold_nxt = hold_cnt + HW'(1);
                    end
                    if (!s_cyc)
                        state_nxt = IDLE;
                    else if (state == G1 && disp_urgent && s_ack &&
                             hold_cnt == HW'(MAX_HOLD - 1))
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_dat_r = '0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_dat_r = '0;
        if (state == G0) begin
            m0_ack   = s_ack;
            m0_err   = s_err || timeout;
            m0_dat_r = s_dat_r;
        end else if (state == G1) begin
            m1_ack   = s_ack;
            m1_err   = s_err || timeout;
            m1_dat_r = s_dat_r;
        end
    end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Arbitrates the single-port framebuffer memory bus, Wishbone classic, between two requesters:
  - m0: display line fetcher that feeds the VGA pixel pipeline; deadline-critical.
  - m1: drawing/CPU writer.
- m0 gets absolute priority while its line FIFO signals urgency. Otherwise grants alternate round-robin.
- Bounds m1 occupancy and recovers from a hung slave via a timeout.

Parameters:
- AW, 24, address width.
- DW, 32, data width; SEL width = DW/8.
- MAX_HOLD, 16, m1 acks allowed while disp_urgent is high before forced release.
- TIMEOUT, 255, cycles of s_stb without ack/err before abort.

Ports:
- pixel_clk  in  1  clock
- pixel_rst  in  1  asynchronous, active-high reset
- m0_cyc, m0_stb, m0_we  in  1 each  display master bus controls
- m0_adr  in  AW  display master address
- m0_dat_w  in  DW  display master write data
- m0_sel  in  DW/8  display master byte selects
- m0_ack, m0_err  out  1 each  display master termination
- m0_dat_r  out  DW  display master read data
- m1_*  same set as m0_*  writer master
- disp_urgent  in  1  display FIFO below low watermark
- s_cyc, s_stb, s_we  out  1 each  slave bus controls
- s_adr  out  AW  slave address
- s_dat_w  out  DW  slave write data
- s_sel  out  DW/8  slave byte selects
- s_ack, s_err  in  1 each  slave termination
- s_dat_r  in  DW  slave read data
- grant  out  2  01 = m0, 10 = m1, 00 = idle
- err_count  out  8  saturating timeout count

Behaviour:
- States: IDLE, G0, G1. State register and `last` register use pixel_clk, pixel_rst asynchronous active-high.
- Reset values:
  - state = IDLE, last = m1 (m0 wins the first tie).
  - hold_cnt = 0, to_cnt = 0, err_count = 0.
  - All s_* controls = 0, all m*_ack/m*_err = 0, grant = 00.
- Reset mid-transfer: s_cyc/s_stb drop the same cycle reset asserts. No ack is forwarded.
- IDLE arbitration, evaluated every cycle:
  - m0_cyc && (disp_urgent || last == m1 || !m1_cyc) -> G0.
  - else m1_cyc -> G1.
  - else stay IDLE.
  - Grant is registered: the slave sees cyc/stb the cycle after the request is sampled (1-cycle latency).
- Entering Gx: last <= x, hold_cnt <= 0, to_cnt <= 0.
- In Gx:
  - s_* = mx_* combinationally.
  - mx_ack = s_ack, mx_err = s_err, mx_dat_r = s_dat_r.
  - The non-granted master sees ack = err = 0 and dat_r = 0.
- Release: the granted master drops cyc -> IDLE next cycle. Minimum one IDLE cycle between any two grants.
- Preemption, G1 only:
  - hold_cnt increments on each s_ack while disp_urgent = 1; it clears when disp_urgent = 0.
  - When hold_cnt reaches MAX_HOLD, on the cycle of that ack state -> IDLE. s_cyc goes low the next cycle even though m1_cyc is still high.
  - m1 stalls (no ack) until regranted. The IDLE rule then grants m0.
  - G0 is never preempted.
- Timeout:
  - to_cnt increments each cycle s_stb = 1 && !s_ack && !s_err, and clears on ack/err.
  - At to_cnt == TIMEOUT: one-cycle mx_err = 1 to the granted master, err_count += 1 (saturates at 255), state -> IDLE.
  - A late s_ack after abort is ignored.
- Simultaneous events:
  - s_ack and timeout in the same cycle: ack wins, no err.
  - Master drops cyc in the same cycle as a preemption: plain release.
  - s_err from the slave is passed through and does not count.
- m*_dat_r/s_dat_w are pure muxes with no registering. Widths are fixed by the parameters, with no truncation.

Test Plan:
- After reset: m0_cyc and m1_cyc rise together, disp_urgent = 0 -> grant = 01 two cycles later. m0 drops cyc -> IDLE for 1 cycle, then grant = 10.
- Alternation: both masters request continuously, 1 transfer each, disp_urgent = 0 -> grant sequence 01, 00, 10, 00, 01. Each m*_ack matches only its own s_ack.
- Urgency: last = m0, disp_urgent = 1, both requesting -> grant = 01, overriding round-robin.
- Preemption: m1 granted with an 8-cycle-ack burst, disp_urgent = 1 from the start, MAX_HOLD = 4 -> s_cyc low after the 4th ack. Grant goes 00 then 01. m1 receives exactly 4 acks before m0 is served.
- Timeout: slave never acks, TIMEOUT = 255 -> m1_err pulses 1 cycle after 255 stalled cycles, err_count = 1, grant = 00. Repeat 300 times -> err_count = 255.
- Reset mid-transfer: pixel_rst asserted during G0 with s_stb = 1 -> s_cyc = 0 and grant = 00 immediately. A s_ack during reset produces no m0_ack.
